cache_memory_arbiter: RTL and testbench
=======================================

// Module: cache_memory_arbiter
// PURPOSE
// Shares the single 64-bit Avalon-MM burst memory port between the instruction cache (read-only
// line fills) and the data cache (line fills and write-backs). Sits between both cache memory
// interfaces and main memory. Grants one whole burst at a time and holds the grant until the last beat.
// PARAMETERS
// data_width    64  memory/cache beat width in bits
// burst_width   4   width of every burstcount port
// priority_mode 0   0 = round-robin between caches, 1 = data cache always wins ties
// PORTS
// clock                 in  1   single clock; all state changes on rising edge
// reset                 in  1   asynchronous, active-low; clears all state
// i_address             in  32  icache burst start address
// i_read                in  1   icache read request, held until i_waitrequest low
// i_burstcount          in  4   icache beats requested
// i_waitrequest         out 1   icache command stall
// i_readdata            out 64  icache read beat
// i_readdatavalid       out 1   icache beat valid
// d_address             in  32  dcache burst start address
// d_read / d_write      in  1   dcache read / write request
// d_burstcount          in  4   dcache beats
// d_writedata           in  64  dcache write beat
// d_byteenable          in  8   dcache write byte lanes
// d_waitrequest         out 1   dcache command/write-beat stall
// d_readdata            out 64  dcache read beat
// d_readdatavalid       out 1   dcache beat valid
// memory_address        out 32  memory port address
// memory_read / memory_write out 1 memory port read / write
// memory_burstcount     out 4   memory burst length
// memory_writedata      out 64  memory write beat
// memory_byteenable     out 8   memory write byte lanes
// memory_waitrequest    in  1   memory stall
// memory_readdata       in  64  memory read beat
// memory_readdatavalid  in  1   memory beat valid
// BEHAVIOUR
// - States: IDLE, CMD, RDATA, WDATA; registers state, owner (I/D), last_owner, beats_left (4b).
// - Reset (reset=0, async): state=IDLE, last_owner=D, beats_left=0; memory_read=memory_write=0,
//   memory_address/burstcount/writedata/byteenable=0, i/d_waitrequest=1, i/d_readdatavalid=0.
// - IDLE: memory outputs zero, both waitrequests high. Requesters: i_read; d_read|d_write.
//   One requester -> grant it. Both -> priority_mode 0: requester != last_owner; 1: D.
//   Grant registered: CMD next cycle (1-cycle arbitration latency). last_owner updated on grant.
// - CMD: owner's command routed combinationally to memory; owner waitrequest = memory_waitrequest,
//   other waitrequest = 1. On accept (memory_waitrequest=0): read -> beats_left=burstcount, RDATA;
//   write (first beat accepted) -> beats_left=burstcount-1, WDATA, or IDLE if 0.
// - Owner drops its request in CMD before accept (protocol violation): abandon, return to IDLE.
// - RDATA: i_readdata = d_readdata = memory_readdata always; memory_readdatavalid forwarded only to
//   owner. Decrement per valid beat; valid with beats_left=1 -> IDLE next cycle.
// - WDATA: d_write/d_writedata/d_byteenable routed to memory, memory_address/burstcount held from
//   the command; decrement per accepted beat; last accepted beat -> IDLE.
// - memory_readdatavalid outside RDATA: ignored, never forwarded.
// - burstcount=0 treated as 1. d_read and d_write both high: read wins.
// - Minimum 1 IDLE cycle between bursts; each cache waits at most one foreign burst in mode 0.
// - Reset mid-burst: aborts immediately; late memory beats after reset are dropped.
// STRUCTURE
// - Shared include cache_mem_defs.vh: state encodings, OWNER_I/OWNER_D, data/burst width localparams
//   reused by instruction and data cache memory interfaces.
// - Sub-module cache_arbiter_grant: combinational two-way round-robin/fixed-priority pick from
//   requests, last_owner, priority_mode. Beat counter and FSM stay in this module.
// TESTING
// - Reset: hold reset=0 with i_read=1 -> memory_read=0, i_waitrequest=1, no grant until release.
// - icache alone: i_read, addr 0x00001040, burst 8, waitrequest low 2 cycles -> memory_read first
//   cycle after request, 8 beats reach i_readdatavalid only, IDLE after beat 8.
// - Simultaneous i_read and d_read, mode 0, last_owner=D -> icache burst first, dcache next; repeated
//   contention alternates I,D,I,D; mode 1 -> D every time.
// - dcache write-back burst 8 with memory_waitrequest toggling every other cycle -> exactly 8 beats
//   accepted in order with matching byteenable, then IDLE.
// - Stray memory_readdatavalid in IDLE and during WDATA -> neither readdatavalid asserted.
// - Reset asserted after beat 3 of 8 -> IDLE immediately, remaining beats dropped, new request served.

Source files
------------

// File: rtl/cache_memory_arbiter_pkg.sv
// Shared types for the cache/memory burst arbiter: FSM states, owner encoding and
// the default port widths used by both cache-side memory interfaces.
package cache_memory_arbiter_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int DATA_WIDTH  = 64;
    localparam int BURST_WIDTH = 4;
    localparam int BE_WIDTH    = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_RDATA = 2'd2,
        ST_WDATA = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

endpackage

// File: rtl/cache_arbiter_grant.sv
// Two-way grant pick between the instruction and data cache: round-robin against the
// previous owner, or data cache wins every tie when fixed priority is selected.
module cache_arbiter_grant
    import cache_memory_arbiter_pkg::*;
(
    input  logic   icache_req_i,
    input  logic   dcache_req_i,
    input  owner_e last_owner_i,
    input  logic   priority_mode_i,
    output logic   grant_valid_o,
    output owner_e grant_owner_o
);

    always_comb begin
        grant_valid_o = icache_req_i | dcache_req_i;
        grant_owner_o = OWNER_D;
        if (icache_req_i && dcache_req_i) begin
            if (priority_mode_i) begin
                grant_owner_o = OWNER_D;
            end else begin
                grant_owner_o = (last_owner_i == OWNER_I) ? OWNER_D : OWNER_I;
            end
        end else if (icache_req_i) begin
            grant_owner_o = OWNER_I;
        end
    end

endmodule

// File: rtl/cache_memory_arbiter.sv
// Shares one Avalon-MM burst memory port between the instruction cache (line fills) and
// the data cache (line fills and write-backs), one whole burst per grant.
module cache_memory_arbiter
    import cache_memory_arbiter_pkg::*;
#(
    parameter int data_width    = DATA_WIDTH,
    parameter int burst_width   = BURST_WIDTH,
    parameter int priority_mode = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [31:0]             i_address,
    input  logic                    i_read,
    input  logic [burst_width-1:0]  i_burstcount,
    output logic                    i_waitrequest,
    output logic [data_width-1:0]   i_readdata,
    output logic                    i_readdatavalid,
    input  logic [31:0]             d_address,
    input  logic                    d_read,
    input  logic                    d_write,
    input  logic [burst_width-1:0]  d_burstcount,
    input  logic [data_width-1:0]   d_writedata,
    input  logic [data_width/8-1:0] d_byteenable,
    output logic                    d_waitrequest,
    output logic [data_width-1:0]   d_readdata,
    output logic                    d_readdatavalid,
    output logic [31:0]             memory_address,
    output logic                    memory_read,
    output logic                    memory_write,
    output logic [burst_width-1:0]  memory_burstcount,
    output logic [data_width-1:0]   memory_writedata,
    output logic [data_width/8-1:0] memory_byteenable,
    input  logic                    memory_waitrequest,
    input  logic [data_width-1:0]   memory_readdata,
    input  logic                    memory_readdatavalid,
    output arb_state_e              dbg_state_o
);

    // Avalon-MM: a command or write beat transfers on a rising edge where it is asserted
    // and its waitrequest is low; read beats transfer on every edge with readdatavalid high.

    arb_state_e             state_q, state_d;
    owner_e                 owner_q, owner_d;
    owner_e                 last_owner_q, last_owner_d;
    logic [burst_width-1:0] beats_left_q, beats_left_d;
    logic [31:0]            cmd_addr_q, cmd_addr_d;
    logic [burst_width-1:0] cmd_burst_q, cmd_burst_d;

    logic                   grant_valid;
    owner_e                 grant_owner;
    logic                   own_req;
    logic                   own_is_read;
    logic [31:0]            own_addr;
    logic [burst_width-1:0] own_burst;
    logic [burst_width-1:0] eff_burst;

    cache_arbiter_grant u_grant (
        .icache_req_i    (i_read),
        .dcache_req_i    (d_read | d_write),
        .last_owner_i    (last_owner_q),
        .priority_mode_i (priority_mode != 0),
        .grant_valid_o   (grant_valid),
        .grant_owner_o   (grant_owner)
    );

    // The icache only ever reads; a dcache asserting read and write together is served as a read.
    assign own_req     = (owner_q == OWNER_I) ? i_read : (d_read | d_write);
    assign own_is_read = (owner_q == OWNER_I) ? 1'b1 : d_read;
    assign own_addr    = (owner_q == OWNER_I) ? i_address : d_address;
    assign own_burst   = (owner_q == OWNER_I) ? i_burstcount : d_burstcount;
    assign eff_burst   = (own_burst == '0) ? burst_width'(1) : own_burst;

    assign i_readdata  = memory_readdata;
    assign d_readdata  = memory_readdata;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d           = state_q;
        owner_d           = owner_q;
        last_owner_d      = last_owner_q;
        beats_left_d      = beats_left_q;
        cmd_addr_d        = cmd_addr_q;
        cmd_burst_d       = cmd_burst_q;
        memory_address    = '0;
        memory_read       = 1'b0;
        memory_write      = 1'b0;
        memory_burstcount = '0;
        memory_writedata  = '0;
        memory_byteenable = '0;
        i_waitrequest     = 1'b1;
        d_waitrequest     = 1'b1;
        i_readdatavalid   = 1'b0;
        d_readdatavalid   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    owner_d      = grant_owner;
                    last_owner_d = grant_owner;
                    state_d      = ST_CMD;
                end
            end
            ST_CMD: begin
                if (!own_req) begin
                    state_d = ST_IDLE;
                end else begin
                    memory_address    = own_addr;
                    memory_burstcount = eff_burst;
                    memory_read       = own_is_read;
                    memory_write      = !own_is_read;
                    if (!own_is_read) begin
                        memory_writedata  = d_writedata;
                        memory_byteenable = d_byteenable;
                    end
                    if (owner_q == OWNER_I) begin
                        i_waitrequest = memory_waitrequest;
                    end else begin
                        d_waitrequest = memory_waitrequest;
                    end
                    if (!memory_waitrequest) begin
                        cmd_addr_d  = own_addr;
                        cmd_burst_d = eff_burst;
                        if (own_is_read) begin
                            beats_left_d = eff_burst;
                            state_d      = ST_RDATA;
                        end else begin
                            // The command cycle also carries the first write beat.
                            beats_left_d = eff_burst - burst_width'(1);
                            state_d      = (eff_burst == burst_width'(1)) ? ST_IDLE : ST_WDATA;
                        end
                    end
                end
            end
            ST_RDATA: begin
                if (memory_readdatavalid) begin
                    if (owner_q == OWNER_I) begin
                        i_readdatavalid = 1'b1;
                    end else begin
                        d_readdatavalid = 1'b1;
                    end
                    beats_left_d = beats_left_q - burst_width'(1);
                    if (beats_left_q <= burst_width'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WDATA: begin
                memory_address    = cmd_addr_q;
                memory_burstcount = cmd_burst_q;
                memory_write      = d_write;
                memory_writedata  = d_writedata;
                memory_byteenable = d_byteenable;
                d_waitrequest     = memory_waitrequest;
                if (d_write && !memory_waitrequest) begin
                    beats_left_d = beats_left_q - burst_width'(1);
                    if (beats_left_q <= burst_width'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWNER_D;
            last_owner_q <= OWNER_D;
            beats_left_q <= '0;
            cmd_addr_q   <= '0;
            cmd_burst_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beats_left_q <= beats_left_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_burst_q  <= cmd_burst_d;
        end
    end

endmodule

// File: tb/tb_cache_memory_arbiter.sv
// Bench for cache_memory_arbiter: behavioural burst memory, per-cache read-data scoreboards,
// a write-beat scoreboard at the memory port and a fixed-priority instance driven directly.
module tb_cache_memory_arbiter;
  import cache_memory_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // ---------------- round-robin DUT signals ----------------
  logic [31:0] i_address, d_address, memory_address;
  logic        i_read, d_read, d_write;
  logic [3:0]  i_burstcount, d_burstcount, memory_burstcount;
  logic        i_waitrequest, d_waitrequest, i_readdatavalid, d_readdatavalid;
  logic [63:0] i_readdata, d_readdata, d_writedata, memory_writedata, memory_readdata;
  logic [7:0]  d_byteenable, memory_byteenable;
  logic        memory_read, memory_write, memory_waitrequest, memory_readdatavalid;
  arb_state_e  dbg_state;

  // ---------------- fixed-priority DUT signals ----------------
  logic [31:0] f_i_address, f_d_address, f_memory_address;
  logic        f_i_read, f_d_read, f_d_write;
  logic [3:0]  f_i_burstcount, f_d_burstcount, f_memory_burstcount;
  logic        f_i_waitrequest, f_d_waitrequest, f_i_readdatavalid, f_d_readdatavalid;
  logic [63:0] f_i_readdata, f_d_readdata, f_d_writedata, f_memory_writedata, f_memory_readdata;
  logic [7:0]  f_d_byteenable, f_memory_byteenable;
  logic        f_memory_read, f_memory_write, f_memory_waitrequest, f_memory_readdatavalid;
  arb_state_e  f_dbg_state;

  cache_memory_arbiter #(.data_width(64), .burst_width(4), .priority_mode(0)) dut (
    .clock(clock), .reset(reset),
    .i_address(i_address), .i_read(i_read), .i_burstcount(i_burstcount),
    .i_waitrequest(i_waitrequest), .i_readdata(i_readdata), .i_readdatavalid(i_readdatavalid),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_burstcount(d_burstcount),
    .d_writedata(d_writedata), .d_byteenable(d_byteenable), .d_waitrequest(d_waitrequest),
    .d_readdata(d_readdata), .d_readdatavalid(d_readdatavalid),
    .memory_address(memory_address), .memory_read(memory_read), .memory_write(memory_write),
    .memory_burstcount(memory_burstcount), .memory_writedata(memory_writedata),
    .memory_byteenable(memory_byteenable), .memory_waitrequest(memory_waitrequest),
    .memory_readdata(memory_readdata), .memory_readdatavalid(memory_readdatavalid),
    .dbg_state_o(dbg_state)
  );

  cache_memory_arbiter #(.data_width(64), .burst_width(4), .priority_mode(1)) dut_fp (
    .clock(clock), .reset(reset),
    .i_address(f_i_address), .i_read(f_i_read), .i_burstcount(f_i_burstcount),
    .i_waitrequest(f_i_waitrequest), .i_readdata(f_i_readdata), .i_readdatavalid(f_i_readdatavalid),
    .d_address(f_d_address), .d_read(f_d_read), .d_write(f_d_write), .d_burstcount(f_d_burstcount),
    .d_writedata(f_d_writedata), .d_byteenable(f_d_byteenable), .d_waitrequest(f_d_waitrequest),
    .d_readdata(f_d_readdata), .d_readdatavalid(f_d_readdatavalid),
    .memory_address(f_memory_address), .memory_read(f_memory_read), .memory_write(f_memory_write),
    .memory_burstcount(f_memory_burstcount), .memory_writedata(f_memory_writedata),
    .memory_byteenable(f_memory_byteenable), .memory_waitrequest(f_memory_waitrequest),
    .memory_readdata(f_memory_readdata), .memory_readdatavalid(f_memory_readdatavalid),
    .dbg_state_o(f_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [63:0]  exp_i_q[$];
  logic [63:0]  exp_d_q[$];
  logic [107:0] exp_w_q[$];   // {address, burstcount, byteenable, writedata}
  logic [31:0]  grant_log[$];

  function automatic logic [63:0] rd_data(input logic [31:0] a, input int k);
    return {a + 32'(k * 8), 32'hC0DE_0000 | 32'(k)};
  endfunction

  // ---------------- behavioural memory ----------------
  int          wait_mode = 0;   // 0: never stall, 1: stall every other cycle, 2: always stall
  bit          inject_stray = 1'b0;
  logic [31:0] rd_addr = '0;
  int          rd_left = 0;
  int          rd_idx = 0;

  always @(negedge clock) begin
    if (reset && !memory_waitrequest) begin
      if (memory_read) begin
        grant_log.push_back(memory_address);
        rd_addr = memory_address;
        rd_left = (memory_burstcount == 4'd0) ? 1 : int'(memory_burstcount);
        rd_idx  = 0;
      end else if (memory_write) begin
        logic [107:0] exp_w;
        checks++;
        if (exp_w_q.size() == 0) begin
          errors++;
          $display("FAIL mem_write_unexpected: got addr=%h data=%h, expected no write", memory_address, memory_writedata);
        end else begin
          exp_w = exp_w_q.pop_front();
          if ({memory_address, memory_burstcount, memory_byteenable, memory_writedata} !== exp_w) begin
            errors++;
            $display("FAIL mem_write_beat: got %h, expected %h",
                     {memory_address, memory_burstcount, memory_byteenable, memory_writedata}, exp_w);
          end
        end
      end
    end
  end

  always @(posedge clock) begin
    #2;
    case (wait_mode)
      0:       memory_waitrequest = 1'b0;
      1:       memory_waitrequest = ~memory_waitrequest;
      default: memory_waitrequest = 1'b1;
    endcase
    memory_readdatavalid = 1'b0;
    memory_readdata      = {$urandom, $urandom};
    if (inject_stray) begin
      memory_readdatavalid = 1'b1;
      memory_readdata      = 64'hDEAD_BEEF_0BAD_F00D;
    end else if (rd_left > 0 && (wait_mode != 1 || memory_waitrequest)) begin
      memory_readdatavalid = 1'b1;
      memory_readdata      = rd_data(rd_addr, rd_idx);
      rd_idx++;
      rd_left--;
    end
  end

  // ---------------- read-beat monitor ----------------
  always @(negedge clock) begin
    if (i_readdatavalid) begin
      checks++;
      if (exp_i_q.size() == 0) begin
        errors++;
        $display("FAIL i_beat_unexpected: got data=%h, expected no beat", i_readdata);
      end else begin
        logic [63:0] e;
        e = exp_i_q.pop_front();
        if (i_readdata !== e) begin
          errors++;
          $display("FAIL i_beat_data: got %h, expected %h", i_readdata, e);
        end
      end
    end
    if (d_readdatavalid) begin
      checks++;
      if (exp_d_q.size() == 0) begin
        errors++;
        $display("FAIL d_beat_unexpected: got data=%h, expected no beat", d_readdata);
      end else begin
        logic [63:0] e;
        e = exp_d_q.pop_front();
        if (d_readdata !== e) begin
          errors++;
          $display("FAIL d_beat_data: got %h, expected %h", d_readdata, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_i_read(input logic [31:0] addr, input logic [3:0] bc);
    bit ok = 1'b0;
    for (int k = 0; k < ((bc == 4'd0) ? 1 : int'(bc)); k++) exp_i_q.push_back(rd_data(addr, k));
    i_address = addr; i_burstcount = bc; i_read = 1'b1;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clock);
      if (!i_waitrequest) ok = 1'b1;
      step();
    end
    i_read = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL i_cmd_timeout: addr=%h never accepted, expected acceptance", addr);
    end
  endtask

  task automatic drive_d_read(input logic [31:0] addr, input logic [3:0] bc);
    bit ok = 1'b0;
    for (int k = 0; k < ((bc == 4'd0) ? 1 : int'(bc)); k++) exp_d_q.push_back(rd_data(addr, k));
    d_address = addr; d_burstcount = bc; d_read = 1'b1;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clock);
      if (!d_waitrequest) ok = 1'b1;
      step();
    end
    d_read = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL d_cmd_timeout: addr=%h never accepted, expected acceptance", addr);
    end
  endtask

  task automatic drive_d_write(input logic [31:0] addr, input logic [3:0] bc);
    logic [63:0] wd[16];
    logic [7:0]  wb[16];
    int n = (bc == 4'd0) ? 1 : int'(bc);
    int k = 0;
    bit acc;
    for (int j = 0; j < n; j++) begin
      wd[j] = {$urandom, $urandom};
      wb[j] = 8'($urandom_range(1, 255));
      exp_w_q.push_back({addr, 4'(n), wb[j], wd[j]});
    end
    d_address = addr; d_burstcount = bc; d_write = 1'b1;
    d_writedata = wd[0]; d_byteenable = wb[0];
    for (int c = 0; c < 400 && k < n; c++) begin
      @(negedge clock);
      acc = !d_waitrequest;
      step();
      if (acc) begin
        k++;
        if (k < n) begin
          d_writedata = wd[k]; d_byteenable = wb[k];
        end
      end
    end
    d_write = 1'b0;
    checks++;
    if (k != n) begin
      errors++;
      $display("FAIL d_write_timeout: accepted %0d beats, expected %0d", k, n);
    end
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clock);
      if (exp_i_q.size() == 0 && exp_d_q.size() == 0 && exp_w_q.size() == 0 && dbg_state == ST_IDLE)
        done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: pending i=%0d d=%0d w=%0d state=%0d, expected all 0 and IDLE",
               exp_i_q.size(), exp_d_q.size(), exp_w_q.size(), dbg_state);
    end
    step();
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_address = 32'h0000_1000; i_burstcount = 4'd4; i_read = 1'b1;
    for (int k = 0; k < 4; k++) exp_i_q.push_back(rd_data(32'h0000_1000, k));
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if (memory_read !== 1'b0 || i_waitrequest !== 1'b1 || d_waitrequest !== 1'b1 ||
          memory_address !== 32'h0 || i_readdatavalid !== 1'b0 || dbg_state !== ST_IDLE) begin
        errors++;
        $display("FAIL reset_hold: mrd=%b iwait=%b dwait=%b maddr=%h state=%0d, expected 0 1 1 0 IDLE",
                 memory_read, i_waitrequest, d_waitrequest, memory_address, dbg_state);
      end
    end
    step();
    reset = 1'b1;
    step();
    checks++;
    if (dbg_state !== ST_CMD || memory_read !== 1'b1 || memory_address !== 32'h0000_1000) begin
      errors++;
      $display("FAIL reset_release_grant: state=%0d mrd=%b maddr=%h, expected CMD 1 00001000",
               dbg_state, memory_read, memory_address);
    end
    step();
    i_read = 1'b0;
    wait_drain();
  endtask

  task automatic test_icache_alone();
    bit ok = 1'b0;
    wait_mode = 1;
    grant_log.delete();
    for (int k = 0; k < 8; k++) exp_i_q.push_back(rd_data(32'h0000_1040, k));
    i_address = 32'h0000_1040; i_burstcount = 4'd8; i_read = 1'b1;
    step();
    checks++;
    if (memory_read !== 1'b1 || memory_address !== 32'h0000_1040 || memory_burstcount !== 4'd8 ||
        memory_write !== 1'b0 || d_waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL icache_cmd: mrd=%b maddr=%h mbc=%0d mwr=%b dwait=%b, expected 1 00001040 8 0 1",
               memory_read, memory_address, memory_burstcount, memory_write, d_waitrequest);
    end
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clock);
      if (!i_waitrequest) ok = 1'b1;
      step();
    end
    i_read = 1'b0;
    wait_drain();
    checks++;
    if (!ok || grant_log.size() != 1 || grant_log[0] !== 32'h0000_1040) begin
      errors++;
      $display("FAIL icache_grant_log: accepted=%b entries=%0d, expected 1 entry at 00001040", ok, grant_log.size());
    end
    wait_mode = 0;
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_order[$];
    pulse_reset();
    grant_log.delete();
    for (int k = 0; k < 3; k++) begin
      exp_order.push_back(32'h0000_1000 + 32'(k * 32'h100));
      exp_order.push_back(32'h0000_2000 + 32'(k * 32'h100));
    end
    fork
      for (int k = 0; k < 3; k++) drive_i_read(32'h0000_1000 + 32'(k * 32'h100), 4'd4);
      for (int k = 0; k < 3; k++) drive_d_read(32'h0000_2000 + 32'(k * 32'h100), 4'd4);
    join
    wait_drain();
    checks++;
    if (grant_log.size() != 6) begin
      errors++;
      $display("FAIL rr_count: got %0d bursts, expected 6", grant_log.size());
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (k >= grant_log.size() || grant_log[k] !== exp_order[k]) begin
        errors++;
        $display("FAIL rr_order[%0d]: got %h, expected %h", k,
                 (k < grant_log.size()) ? grant_log[k] : 32'hx, exp_order[k]);
      end
    end
  endtask

  task automatic test_fixed_priority();
    f_i_address = 32'h0000_1100; f_i_burstcount = 4'd1; f_i_read = 1'b1;
    f_d_address = 32'h0000_2100; f_d_burstcount = 4'd1; f_d_read = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (f_memory_read !== 1'b1 || f_memory_address !== 32'h0000_2100 + 32'(k * 32'h40) ||
          f_i_waitrequest !== 1'b1) begin
        errors++;
        $display("FAIL fp_grant[%0d]: mrd=%b maddr=%h iwait=%b, expected 1 %h 1", k,
                 f_memory_read, f_memory_address, f_i_waitrequest, 32'h0000_2100 + 32'(k * 32'h40));
      end
      step();
      f_d_address = 32'h0000_2100 + 32'((k + 1) * 32'h40);
      f_memory_readdata = rd_data(32'h0000_2100, k);
      f_memory_readdatavalid = 1'b1;
      #1;
      checks++;
      if (f_d_readdatavalid !== 1'b1 || f_i_readdatavalid !== 1'b0 || f_d_readdata !== rd_data(32'h0000_2100, k)) begin
        errors++;
        $display("FAIL fp_beat[%0d]: dvalid=%b ivalid=%b data=%h, expected 1 0 %h", k,
                 f_d_readdatavalid, f_i_readdatavalid, f_d_readdata, rd_data(32'h0000_2100, k));
      end
      step();
      f_memory_readdatavalid = 1'b0;
    end
    f_d_read = 1'b0;
    step();
    checks++;
    if (f_memory_read !== 1'b1 || f_memory_address !== 32'h0000_1100) begin
      errors++;
      $display("FAIL fp_icache_after: mrd=%b maddr=%h, expected 1 00001100", f_memory_read, f_memory_address);
    end
    step();
    f_i_read = 1'b0;
    f_memory_readdatavalid = 1'b1;
    #1;
    checks++;
    if (f_i_readdatavalid !== 1'b1 || f_d_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL fp_icache_beat: ivalid=%b dvalid=%b, expected 1 0", f_i_readdatavalid, f_d_readdatavalid);
    end
    step();
    f_memory_readdatavalid = 1'b0;
    checks++;
    if (f_dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL fp_idle: state=%0d, expected IDLE", f_dbg_state);
    end
  endtask

  task automatic test_write_burst();
    wait_mode = 1;
    drive_d_write(32'h0000_2400, 4'd8);
    wait_drain();
    wait_mode = 0;
  endtask

  task automatic test_stray_valid();
    bit seen = 1'b0;
    inject_stray = 1'b1;
    step();
    @(negedge clock);
    checks++;
    if (i_readdatavalid !== 1'b0 || d_readdatavalid !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL stray_idle: ivalid=%b dvalid=%b state=%0d, expected 0 0 IDLE",
               i_readdatavalid, d_readdatavalid, dbg_state);
    end
    step();
    inject_stray = 1'b0;
    wait_mode = 1;
    fork
      drive_d_write(32'h0000_2800, 4'd8);
      begin
        for (int c = 0; c < 50 && !seen; c++) begin
          step();
          if (dbg_state == ST_WDATA) seen = 1'b1;
        end
        inject_stray = 1'b1;
        step();
        @(negedge clock);
        checks++;
        if (!seen || i_readdatavalid !== 1'b0 || d_readdatavalid !== 1'b0) begin
          errors++;
          $display("FAIL stray_wdata: reached=%b ivalid=%b dvalid=%b, expected 1 0 0",
                   seen, i_readdatavalid, d_readdatavalid);
        end
        step();
        inject_stray = 1'b0;
      end
    join
    wait_drain();
    wait_mode = 0;
  endtask

  task automatic test_boundaries();
    d_address = 32'h0000_3000; d_burstcount = 4'd0; d_read = 1'b1; d_write = 1'b1;
    d_writedata = 64'h1111_2222_3333_4444; d_byteenable = 8'hFF;
    exp_d_q.push_back(rd_data(32'h0000_3000, 0));
    step();
    checks++;
    if (memory_read !== 1'b1 || memory_write !== 1'b0 || memory_burstcount !== 4'd1 || d_waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL read_wins_bc0: mrd=%b mwr=%b mbc=%0d dwait=%b, expected 1 0 1 0",
               memory_read, memory_write, memory_burstcount, d_waitrequest);
    end
    step();
    d_read = 1'b0; d_write = 1'b0;
    wait_drain();
    wait_mode = 2;
    step();
    step();
    i_address = 32'h0000_1F00; i_burstcount = 4'd2; i_read = 1'b1;
    step();
    step();
    checks++;
    if (dbg_state !== ST_CMD || i_waitrequest !== 1'b1 || memory_read !== 1'b1) begin
      errors++;
      $display("FAIL stall_cmd: state=%0d iwait=%b mrd=%b, expected CMD 1 1", dbg_state, i_waitrequest, memory_read);
    end
    i_read = 1'b0;
    #1;
    checks++;
    if (memory_read !== 1'b0) begin
      errors++;
      $display("FAIL drop_cmd_mrd: mrd=%b, expected 0", memory_read);
    end
    step();
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL drop_cmd_idle: state=%0d, expected IDLE", dbg_state);
    end
    wait_mode = 0;
    step();
  endtask

  task automatic test_reset_mid_burst();
    bit hit = 1'b0;
    drive_i_read(32'h0000_1800, 4'd8);
    for (int c = 0; c < 100 && !hit; c++) begin
      @(posedge clock);
      #3;
      if (exp_i_q.size() <= 5) hit = 1'b1;
    end
    reset = 1'b0;
    #1;
    checks++;
    if (!hit || dbg_state !== ST_IDLE || i_readdatavalid !== 1'b0 || memory_read !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_burst: reached=%b state=%0d ivalid=%b mrd=%b, expected 1 IDLE 0 0",
               hit, dbg_state, i_readdatavalid, memory_read);
    end
    exp_i_q.delete();
    step();
    step();
    reset = 1'b1;
    repeat (10) step();
    drive_i_read(32'h0000_1900, 4'd2);
    wait_drain();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b0;
    i_address = '0; i_read = 1'b0; i_burstcount = '0;
    d_address = '0; d_read = 1'b0; d_write = 1'b0; d_burstcount = '0;
    d_writedata = '0; d_byteenable = '0;
    memory_waitrequest = 1'b0; memory_readdatavalid = 1'b0; memory_readdata = '0;
    f_i_address = '0; f_i_read = 1'b0; f_i_burstcount = '0;
    f_d_address = '0; f_d_read = 1'b0; f_d_write = 1'b0; f_d_burstcount = '0;
    f_d_writedata = '0; f_d_byteenable = '0;
    f_memory_waitrequest = 1'b0; f_memory_readdatavalid = 1'b0; f_memory_readdata = '0;
    step();
    step();
    test_reset();
    test_icache_alone();
    test_round_robin();
    test_fixed_priority();
    test_write_burst();
    test_stray_valid();
    test_boundaries();
    test_reset_mid_burst();
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
